// File: rtl/aud_pkg.sv
// Shared types and widths for the audio recorder: word/address sizes and controller states.
package aud_pkg;
    localparam int AUD_WORD_W = 16;
    localparam int AUD_ADDR_W = 20;
    localparam int AUD_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RECV   = 3'd2,
        ST_STORE  = 3'd3,
        ST_PAUSED = 3'd4
    } aud_state_e;
endpackage

// File: rtl/aud_recorder_if.sv
// Link between the recorder controller (master) and the serial-in shifter (slave).
interface aud_recorder_if;
    import aud_pkg::*;

    logic                  clr;
    logic                  shift_en;
    logic                  bit_in;
    logic [AUD_WORD_W-1:0] word;
    logic                  last;

    modport master (output clr, output shift_en, output bit_in, input word, input last);
    modport slave  (input clr, input shift_en, input bit_in, output word, output last);
endinterface

// File: rtl/i2s_rx_shifter.sv
// 16-bit serial-in shift register, MSB first, with a bit counter flagging the final bit.
module i2s_rx_shifter
    import aud_pkg::*;
(
    input  logic          i_bclk,
    input  logic          i_rst,
    aud_recorder_if.slave sh
);
    logic [AUD_WORD_W-1:0] r_word;
    logic [AUD_CNT_W-1:0]  r_cnt;

    always_ff @(posedge i_bclk) begin
        if (i_rst || sh.clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (sh.shift_en) begin
            r_word <= {r_word[AUD_WORD_W-2:0], sh.bit_in};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign sh.word = r_word;
    // High while the bit being shifted in is the 16th of the word.
    assign sh.last = (r_cnt == AUD_CNT_W'(AUD_WORD_W - 1));
endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures 16-bit left samples and writes them to sequential addresses.
//  state  | meaning
//  IDLE   | not recording, waiting for i_start
//  WAIT   | armed, waiting for a left-frame start (LR falling edge)
//  RECV   | shifting in the 16 left-channel bits
//  STORE  | one-cycle write strobe of the captured word
//  PAUSED | recording suspended, address held, waiting for i_start
module aud_recorder
    import aud_pkg::*;
#(
    parameter logic [AUD_ADDR_W-1:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic                  i_bclk,
    input  logic                  i_rst,
    input  logic                  i_lrc,
    input  logic                  i_data,
    input  logic                  i_start,
    input  logic                  i_pause,
    input  logic                  i_stop,
    output logic [AUD_ADDR_W-1:0] o_address,
    output logic [AUD_WORD_W-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_done
);
    aud_state_e            r_state;
    aud_state_e            w_state_nxt;
    logic                  r_lrc_d;
    logic                  r_pause_pend;
    logic [AUD_ADDR_W-1:0] r_addr;
    logic [AUD_WORD_W-1:0] r_data_hold;
    logic                  r_done;
    logic                  w_lframe;
    logic                  w_clr;
    logic                  w_shift;
    logic                  w_at_max;

    aud_recorder_if u_sh_if ();

    i2s_rx_shifter u_shifter (
        .i_bclk (i_bclk),
        .i_rst  (i_rst),
        .sh     (u_sh_if.slave)
    );

    assign u_sh_if.clr      = w_clr;
    assign u_sh_if.shift_en = w_shift;
    assign u_sh_if.bit_in   = i_data;

    assign w_lframe = r_lrc_d & ~i_lrc;
    assign w_at_max = (r_addr == ADDR_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_stop && i_start) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_stop)         w_state_nxt = ST_IDLE;
                else if (i_pause)   w_state_nxt = ST_PAUSED;
                else if (w_lframe) begin
                    w_state_nxt = ST_RECV;
                    w_clr       = 1'b1;
                end
            end
            ST_RECV: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_shift = 1'b1;
                    if (u_sh_if.last) w_state_nxt = ST_STORE;
                end
            end
            ST_STORE: begin
                if (i_stop || w_at_max)            w_state_nxt = ST_IDLE;
                else if (r_pause_pend || i_pause)  w_state_nxt = ST_PAUSED;
                else                               w_state_nxt = ST_WAIT;
            end
            ST_PAUSED: begin
                if (i_stop)                  w_state_nxt = ST_IDLE;
                else if (i_start && !i_pause) w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_lrc_d      <= 1'b1;
            r_pause_pend <= 1'b0;
            r_addr       <= '0;
            r_data_hold  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lrc_d <= i_lrc;
            r_done  <= (r_state == ST_STORE) && !i_stop && w_at_max;

            if (r_state == ST_IDLE && w_state_nxt == ST_WAIT) r_addr <= '0;
            else if (r_state == ST_STORE && w_state_nxt != ST_IDLE) r_addr <= r_addr + 1'b1;

            if (r_state == ST_STORE) r_data_hold <= u_sh_if.word;

            // A pause request seen mid-word is remembered until the word has been stored.
            if (r_state == ST_STORE || w_state_nxt == ST_PAUSED || w_state_nxt == ST_IDLE)
                r_pause_pend <= 1'b0;
            else if ((r_state == ST_WAIT || r_state == ST_RECV) && i_pause)
                r_pause_pend <= 1'b1;
        end
    end

    assign o_address = r_addr;
    assign o_valid   = (r_state == ST_STORE);
    assign o_data    = (r_state == ST_STORE) ? u_sh_if.word : r_data_hold;
    assign o_done    = r_done;
endmodule
